// File: rtl/wb_merge.sv
// Writeback merge: per-thread FIFOs collecting LSU/ALU0/ALU1 results and retiring one write per thread per cycle.
// Defining WB_MERGE_BYPASS_EN lets an accept into an empty FIFO reach the write port in the same cycle.
module wb_merge #(
   parameter int unsigned NUM_Threads = 4,
   parameter int unsigned FIFO_DEPTH  = 4,
   localparam int unsigned TW = (NUM_Threads > 1) ? $clog2(NUM_Threads) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   lsu_valid,
   input  logic [TW-1:0]          lsu_tid,
   input  logic [4:0]             lsu_rd_addr,
   input  logic [31:0]            lsu_rd_data,
   output logic                   lsu_ready,
   input  logic                   alu0_valid,
   input  logic [TW-1:0]          alu0_tid,
   input  logic [4:0]             alu0_rd_addr,
   input  logic [31:0]            alu0_rd_data,
   output logic                   alu0_ready,
   input  logic                   alu1_valid,
   input  logic [TW-1:0]          alu1_tid,
   input  logic [4:0]             alu1_rd_addr,
   input  logic [31:0]            alu1_rd_data,
   output logic                   alu1_ready,
   output logic [NUM_Threads-1:0] rd_wen,
   output logic [4:0]             rd_forward_addr [NUM_Threads-1:0],
   output logic [31:0]            rd_forward_data [NUM_Threads-1:0],
   output logic [NUM_Threads-1:0] thread_busy
);

   localparam int unsigned NS = 3;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

`ifdef WB_MERGE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_entry_t;

   logic [NS-1:0]          src_valid, src_ready, src_acc;
   logic [TW-1:0]          src_tid   [NS];
   wb_entry_t              src_ent   [NS];
   logic [PW-1:0]          need      [NS];

   logic [PW-1:0]          wr_ptr    [NUM_Threads];
   logic [PW-1:0]          rd_ptr    [NUM_Threads];
   logic [PW-1:0]          count     [NUM_Threads];
   logic [PW-1:0]          free      [NUM_Threads];
   logic [NUM_Threads-1:0] empty, full;
   wb_entry_t              mem       [NUM_Threads][FIFO_DEPTH];

   logic [NS-1:0]          push_en   [NUM_Threads];
   logic [AW-1:0]          push_slot [NUM_Threads][NS];
   logic [1:0]             push_cnt  [NUM_Threads];
   logic [NUM_Threads-1:0] byp_hit;
   wb_entry_t              byp_ent   [NUM_Threads];

   // Sources in priority order: 0 = LSU, 1 = ALU0, 2 = ALU1.
   always_comb begin
      src_valid  = {alu1_valid, alu0_valid, lsu_valid};
      src_tid[0] = lsu_tid;
      src_tid[1] = alu0_tid;
      src_tid[2] = alu1_tid;
      src_ent[0] = {lsu_rd_addr, lsu_rd_data};
      src_ent[1] = {alu0_rd_addr, alu0_rd_data};
      src_ent[2] = {alu1_rd_addr, alu1_rd_data};
   end

   // FIFO status; the head always pops when present, so its slot counts as free.
   always_comb begin
      for (int t = 0; t < NUM_Threads; t++) begin
         count[t] = wr_ptr[t] - rd_ptr[t];
         empty[t] = (wr_ptr[t] == rd_ptr[t]);
         full[t]  = (wr_ptr[t][AW-1:0] == rd_ptr[t][AW-1:0]) && (wr_ptr[t][AW] != rd_ptr[t][AW]);
         free[t]  = full[t] ? PW'(1) : PW'(FIFO_DEPTH) - count[t] + PW'(!empty[t]);
      end
   end

   // Ready never looks at the source's own valid: higher-priority valids to the same thread claim slots first.
   always_comb begin
      src_ready = '0;
      for (int s = 0; s < NS; s++) begin
         need[s] = PW'(1);
         for (int h = 0; h < s; h++) begin
            if (src_valid[h] && (src_tid[h] == src_tid[s])) need[s] = need[s] + PW'(1);
         end
         src_ready[s] = rst && (free[src_tid[s]] >= need[s]);
      end
      src_acc = src_valid & src_ready;
   end

   // Slot allocation in priority order; x0 writes are accepted but dropped.
   always_comb begin
      for (int t = 0; t < NUM_Threads; t++) begin
         push_en[t]  = '0;
         push_cnt[t] = '0;
         byp_hit[t]  = 1'b0;
         byp_ent[t]  = '0;
         for (int s = 0; s < NS; s++) begin
            push_slot[t][s] = '0;
            if (src_acc[s] && (src_tid[s] == TW'(t)) && (src_ent[s].addr != 5'd0)) begin
               if (BYPASS_EN && empty[t] && !byp_hit[t]) begin
                  byp_hit[t] = 1'b1;
                  byp_ent[t] = src_ent[s];
               end else begin
                  push_en[t][s]   = 1'b1;
                  push_slot[t][s] = AW'(wr_ptr[t] + PW'(push_cnt[t]));
                  push_cnt[t]     = push_cnt[t] + 2'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < NUM_Threads; t++) begin
            wr_ptr[t] <= '0;
            rd_ptr[t] <= '0;
         end
      end else begin
         for (int t = 0; t < NUM_Threads; t++) begin
            wr_ptr[t] <= wr_ptr[t] + PW'(push_cnt[t]);
            rd_ptr[t] <= rd_ptr[t] + PW'(!empty[t]);
         end
      end
   end

   // Storage needs no reset: pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      for (int t = 0; t < NUM_Threads; t++) begin
         for (int s = 0; s < NS; s++) begin
            if (push_en[t][s]) mem[t][push_slot[t][s]] <= src_ent[s];
         end
      end
   end

   always_comb begin
      for (int t = 0; t < NUM_Threads; t++) begin
         rd_wen[t]          = 1'b0;
         rd_forward_addr[t] = '0;
         rd_forward_data[t] = '0;
         thread_busy[t]     = !empty[t];
         if (!empty[t]) begin
            rd_wen[t]          = 1'b1;
            rd_forward_addr[t] = mem[t][rd_ptr[t][AW-1:0]].addr;
            rd_forward_data[t] = mem[t][rd_ptr[t][AW-1:0]].data;
         end else if (byp_hit[t]) begin
            rd_wen[t]          = 1'b1;
            rd_forward_addr[t] = byp_ent[t].addr;
            rd_forward_data[t] = byp_ent[t].data;
         end
      end
      lsu_ready  = src_ready[0];
      alu0_ready = src_ready[1];
      alu1_ready = src_ready[2];
   end

endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: directed scenarios then random traffic, checked against per-thread queues.
module tb_wb_merge;

   localparam int unsigned NT    = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TW    = 2;
   localparam int unsigned NS    = 3;

`ifdef WB_MERGE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef logic [36:0] ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          lsu_valid, alu0_valid, alu1_valid;
   logic [TW-1:0] lsu_tid, alu0_tid, alu1_tid;
   logic [4:0]    lsu_rd_addr, alu0_rd_addr, alu1_rd_addr;
   logic [31:0]   lsu_rd_data, alu0_rd_data, alu1_rd_data;
   logic          lsu_ready, alu0_ready, alu1_ready;
   logic [NT-1:0] rd_wen, thread_busy;
   logic [4:0]    rd_forward_addr [NT-1:0];
   logic [31:0]   rd_forward_data [NT-1:0];

   logic [NS-1:0] v;
   logic [TW-1:0] tid [NS];
   logic [4:0]    ad  [NS];
   logic [31:0]   da  [NS];

   int   n_vec = 0;
   int   n_err = 0;
   ent_t mq [NT][$];
   logic [4:0] col_exp [5];
   int   fill;

   always #5 clk = ~clk;

   assign lsu_valid    = v[0];
   assign alu0_valid   = v[1];
   assign alu1_valid   = v[2];
   assign lsu_tid      = tid[0];
   assign alu0_tid     = tid[1];
   assign alu1_tid     = tid[2];
   assign lsu_rd_addr  = ad[0];
   assign alu0_rd_addr = ad[1];
   assign alu1_rd_addr = ad[2];
   assign lsu_rd_data  = da[0];
   assign alu0_rd_data = da[1];
   assign alu1_rd_data = da[2];

   wb_merge #(.NUM_Threads(NT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .lsu_valid(lsu_valid), .lsu_tid(lsu_tid), .lsu_rd_addr(lsu_rd_addr),
      .lsu_rd_data(lsu_rd_data), .lsu_ready(lsu_ready),
      .alu0_valid(alu0_valid), .alu0_tid(alu0_tid), .alu0_rd_addr(alu0_rd_addr),
      .alu0_rd_data(alu0_rd_data), .alu0_ready(alu0_ready),
      .alu1_valid(alu1_valid), .alu1_tid(alu1_tid), .alu1_rd_addr(alu1_rd_addr),
      .alu1_rd_data(alu1_rd_data), .alu1_ready(alu1_ready),
      .rd_wen(rd_wen), .rd_forward_addr(rd_forward_addr),
      .rd_forward_data(rd_forward_data), .thread_busy(thread_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int s, input logic [TW-1:0] t, input logic [4:0] a, input logic [31:0] d);
      v[s] = 1'b1; tid[s] = t; ad[s] = a; da[s] = d;
   endtask

   task automatic idle();
      v = '0;
      for (int s = 0; s < NS; s++) begin
         tid[s] = '0; ad[s] = '0; da[s] = '0;
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // A source is ready when its thread still has a free slot after every higher-priority valid to that thread.
   function automatic logic [NS-1:0] model_ready();
      logic [NS-1:0] r;
      r = '0;
      for (int s = 0; s < NS; s++) begin
         int need, free, sz;
         need = 1;
         for (int h = 0; h < s; h++)
            if (v[h] && tid[h] == tid[s]) need++;
         sz   = mq[tid[s]].size();
         free = int'(DEPTH) - sz + ((sz > 0) ? 1 : 0);
         r[s] = (free >= need);
      end
      return r;
   endfunction

   // Check this cycle's outputs against the queues, then retire heads and enqueue accepts.
   task automatic cycle();
      logic [NS-1:0] er;
      logic [NT-1:0] busy_exp;
      int            byp [NT];
      logic          exp_wen;
      ent_t          exp_ent;
      er = model_ready();
      chk("ready", 64'({alu1_ready, alu0_ready, lsu_ready}), 64'(er));
      for (int t = 0; t < NT; t++) begin
         byp[t] = -1;
         if (BYPASS && mq[t].size() == 0)
            for (int s = 0; s < NS; s++)
               if (byp[t] < 0 && v[s] && er[s] && int'(tid[s]) == t && ad[s] != 5'd0) byp[t] = s;
         exp_wen = 1'b0;
         exp_ent = '0;
         if (mq[t].size() > 0) begin
            exp_wen = 1'b1; exp_ent = mq[t][0];
         end else if (byp[t] >= 0) begin
            exp_wen = 1'b1; exp_ent = {ad[byp[t]], da[byp[t]]};
         end
         busy_exp[t] = (mq[t].size() > 0);
         chk($sformatf("port%0d", t), 64'({rd_wen[t], rd_forward_addr[t], rd_forward_data[t]}),
             64'({exp_wen, exp_ent}));
      end
      chk("busy", 64'(thread_busy), 64'(busy_exp));
      for (int t = 0; t < NT; t++)
         if (mq[t].size() > 0) void'(mq[t].pop_front());
      for (int s = 0; s < NS; s++)
         if (v[s] && er[s] && ad[s] != 5'd0 && byp[tid[s]] != s) mq[tid[s]].push_back({ad[s], da[s]});
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      settle();
      cycle();
   endtask

   initial begin
      rst = 1'b0;
      idle();
      set_src(0, 2'd0, 5'd1, 32'h1);
      set_src(1, 2'd1, 5'd2, 32'h2);
      set_src(2, 2'd2, 5'd3, 32'h3);
      #12;
      chk("rst_ready", 64'({alu1_ready, alu0_ready, lsu_ready}), 64'(0));
      chk("rst_wen", 64'(rd_wen), 64'(0));
      chk("rst_busy", 64'(thread_busy), 64'(0));
      chk("rst_fwd0", 64'({rd_forward_addr[0], rd_forward_data[0]}), 64'(0));
      idle();
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      // Single write to thread 1.
      set_src(1, 2'd1, 5'd5, 32'hDEADBEEF);
      settle();
      chk("single_rdy", 64'(alu0_ready), 64'(1));
      chk("single_wen0", 64'(rd_wen[1]), 64'(BYPASS));
      cycle();
      idle();
      settle();
      chk("single_wen1", 64'({rd_wen[1], rd_forward_addr[1], rd_forward_data[1]}),
          BYPASS ? 64'(0) : 64'({1'b1, 5'd5, 32'hDEADBEEF}));
      cycle();
      step();
      step();

      // Three-way collision on thread 2 retires in LSU, ALU0, ALU1 order.
      if (BYPASS) begin
         col_exp[0] = 5'd3; col_exp[1] = 5'd4; col_exp[2] = 5'd6; col_exp[3] = 5'd0; col_exp[4] = 5'd0;
      end else begin
         col_exp[0] = 5'd0; col_exp[1] = 5'd3; col_exp[2] = 5'd4; col_exp[3] = 5'd6; col_exp[4] = 5'd0;
      end
      set_src(0, 2'd2, 5'd3, 32'h33);
      set_src(1, 2'd2, 5'd4, 32'h44);
      set_src(2, 2'd2, 5'd6, 32'h66);
      for (int i = 0; i < 5; i++) begin
         settle();
         if (i == 0) chk("col_rdy", 64'({alu1_ready, alu0_ready, lsu_ready}), 64'(3'b111));
         chk($sformatf("col_addr%0d", i), 64'(rd_forward_addr[2]), 64'(col_exp[i]));
         cycle();
         idle();
      end

      // Backpressure: two writes per cycle into thread 0 outrun one retire per cycle.
      fill = BYPASS ? 4 : 3;
      for (int i = 0; i < 6; i++) begin
         idle();
         set_src(1, 2'd0, 5'd10, $urandom);
         set_src(2, 2'd0, 5'd11, $urandom);
         settle();
         chk($sformatf("bp_alu0_%0d", i), 64'(alu0_ready), 64'(1));
         chk($sformatf("bp_alu1_%0d", i), 64'(alu1_ready), 64'(i < fill));
         cycle();
      end
      idle();
      repeat (6) step();

      // x0 writes are accepted and dropped.
      set_src(0, 2'd3, 5'd0, 32'h1234);
      settle();
      chk("x0_rdy", 64'(lsu_ready), 64'(1));
      chk("x0_wen", 64'(rd_wen[3]), 64'(0));
      cycle();
      idle();
      settle();
      chk("x0_wen_next", 64'(rd_wen[3]), 64'(0));
      chk("x0_busy_next", 64'(thread_busy[3]), 64'(0));
      cycle();

      // Reset between edges while thread 1 holds entries.
      set_src(0, 2'd1, 5'd1, 32'hA1);
      set_src(1, 2'd1, 5'd2, 32'hA2);
      set_src(2, 2'd1, 5'd3, 32'hA3);
      step();
      #3 rst = 1'b0;
      #1;
      chk("mid_rst_ready", 64'({alu1_ready, alu0_ready, lsu_ready}), 64'(0));
      chk("mid_rst_wen", 64'(rd_wen), 64'(0));
      chk("mid_rst_busy", 64'(thread_busy), 64'(0));
      for (int t = 0; t < NT; t++) mq[t].delete();
      @(posedge clk);
      #3;
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) step();
      set_src(1, 2'd1, 5'd9, 32'hCAFE);
      step();
      idle();
      repeat (2) step();

      // Random traffic, biased toward thread 0 to exercise backpressure.
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int s = 0; s < NS; s++)
            if ($urandom_range(0, 99) < 65)
               set_src(s, ($urandom_range(0, 1) == 1) ? TW'(0) : TW'($urandom_range(0, NT - 1)),
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
         step();
      end
      idle();
      repeat (2 * DEPTH) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
